rtc_bus_driver: RTL

Executes single read or write transactions on the RTC's multiplexed 8-bit address/data bus (CS, RD, WR, A/D strobes). It sits directly downstream of the initialisation/sequencing FSMs. Those FSMs present an address, a data byte and a start pulse. This block converts each request into a correctly timed address phase followed by a data phase, then reports completion with a one-cycle `done` pulse.

---
 rtl/rtc_bus_pkg.sv | 35 +++
 rtl/rtc_bus_driver_phase_timer.sv | 25 ++
 rtl/rtc_bus_driver.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: state encoding, default bus timing and the RTC register map
// shared by the bus driver and the sequencers that feed it.
package rtc_bus_pkg;

    localparam int RTC_BUS_W   = 8;
    localparam int T_SETUP_DEF = 2;
    localparam int T_PULSE_DEF = 4;
    localparam int T_HOLD_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_A_SETUP  = 3'd1,
        ST_A_STROBE = 3'd2,
        ST_A_HOLD   = 3'd3,
        ST_D_SETUP  = 3'd4,
        ST_D_STROBE = 3'd5,
        ST_D_HOLD   = 3'd6,
        ST_DONE     = 3'd7
    } bus_state_e;

    localparam logic [7:0] RTC_REG_CONTROL  = 8'h02;
    localparam logic [7:0] RTC_REG_SECONDS  = 8'h21;
    localparam logic [7:0] RTC_REG_MINUTES  = 8'h22;
    localparam logic [7:0] RTC_REG_HOURS    = 8'h23;
    localparam logic [7:0] RTC_REG_DAY      = 8'h24;
    localparam logic [7:0] RTC_REG_MONTH    = 8'h25;
    localparam logic [7:0] RTC_REG_YEAR     = 8'h26;
    localparam logic [7:0] RTC_REG_TRANSFER = 8'hF0;

    // Phase timer counts from 0, so a phase of N cycles ends at count N-1.
    function automatic logic [7:0] phase_limit(input int cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/rtc_bus_driver_phase_timer.sv
// phase_timer: cycle counter cleared on every phase entry; expire flags the
// final cycle of the current phase.
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] limit,
    output logic       expire
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign expire = (count == limit);

endmodule

// File: rtl/rtc_bus_driver.sv
// rtc_bus_driver: single read/write transaction on the RTC multiplexed A/D bus.
// Reads exist only when RTC_BUS_READ_EN is defined; otherwise every request is a write.
//
// state     | meaning
// IDLE      | bus released, waiting for start
// A_SETUP   | address driven, cs_n low
// A_STROBE  | address strobed with wr_n
// A_HOLD    | address held after wr_n rises
// D_SETUP   | data phase (write drives data, read releases bus)
// D_STROBE  | wr_n or rd_n low; read byte captured on last cycle
// D_HOLD    | strobes high, cs_n and drive unchanged
// DONE      | bus released, one-cycle done pulse
module rtc_bus_driver
    import rtc_bus_pkg::*;
#(
    parameter int BUS_W   = RTC_BUS_W,
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rd_op,
    input  logic [BUS_W-1:0] addr,
    input  logic [BUS_W-1:0] wr_data,
    input  logic [BUS_W-1:0] ad_in,
    output logic [BUS_W-1:0] ad_out,
    output logic             ad_oe,
    output logic             cs_n,
    output logic             rd_n,
    output logic             wr_n,
    output logic             ad_sel,
    output logic [BUS_W-1:0] rd_data,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] IDLE     = ST_IDLE;
    localparam logic [2:0] A_SETUP  = ST_A_SETUP;
    localparam logic [2:0] A_STROBE = ST_A_STROBE;
    localparam logic [2:0] A_HOLD   = ST_A_HOLD;
    localparam logic [2:0] D_SETUP  = ST_D_SETUP;
    localparam logic [2:0] D_STROBE = ST_D_STROBE;
    localparam logic [2:0] D_HOLD   = ST_D_HOLD;
    localparam logic [2:0] DONE     = ST_DONE;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [BUS_W-1:0] addr_q;
    logic [BUS_W-1:0] data_q;
    logic [BUS_W-1:0] addr_nxt;
    logic [BUS_W-1:0] data_nxt;
    logic             accept;
    logic             op_rd;
    logic             load;
    logic             expire;
    logic [7:0]       limit;
    logic             addr_ph;
    logic             data_ph;
    logic             data_drv;

    assign accept   = (state == IDLE) && start;
    assign addr_nxt = accept ? addr : addr_q;
    assign data_nxt = accept ? wr_data : data_q;

    always_comb begin
        case (state)
            A_SETUP, D_SETUP:   limit = phase_limit(T_SETUP);
            A_STROBE, D_STROBE: limit = phase_limit(T_PULSE);
            A_HOLD, D_HOLD:     limit = phase_limit(T_HOLD);
            default:            limit = 8'd0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start)  next_state = A_SETUP;
            A_SETUP:  if (expire) next_state = A_STROBE;
            A_STROBE: if (expire) next_state = A_HOLD;
            A_HOLD:   if (expire) next_state = D_SETUP;
            D_SETUP:  if (expire) next_state = D_STROBE;
            D_STROBE: if (expire) next_state = D_HOLD;
            D_HOLD:   if (expire) next_state = DONE;
            default:              next_state = IDLE;
        endcase
    end

    assign load = (next_state != state);

    phase_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .limit  (limit),
        .expire (expire)
    );

    // Outputs are decoded from the next state so each registered value lines up with its state.
    assign addr_ph  = (next_state == A_SETUP) || (next_state == A_STROBE) || (next_state == A_HOLD);
    assign data_ph  = (next_state == D_SETUP) || (next_state == D_STROBE) || (next_state == D_HOLD);
    assign data_drv = data_ph && !op_rd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            ad_out <= '0;
            ad_oe  <= 1'b0;
            cs_n   <= 1'b1;
            wr_n   <= 1'b1;
            ad_sel <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= next_state;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            cs_n   <= !(addr_ph || data_ph);
            ad_sel <= data_ph;
            ad_oe  <= addr_ph || data_drv;
            ad_out <= addr_ph ? addr_nxt : (data_drv ? data_nxt : '0);
            wr_n   <= !((next_state == A_STROBE) || ((next_state == D_STROBE) && !op_rd));
            busy   <= (next_state != IDLE);
            done   <= (next_state == DONE);
        end
    end

`ifdef RTC_BUS_READ_EN
    logic rd_q;

    assign op_rd = accept ? rd_op : rd_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q    <= 1'b0;
            rd_data <= '0;
            rd_n    <= 1'b1;
        end else begin
            if (accept) begin
                rd_q <= rd_op;
            end
            if ((state == D_STROBE) && expire && rd_q) begin
                rd_data <= ad_in;
            end
            rd_n <= !((next_state == D_STROBE) && op_rd);
        end
    end
`else
    logic unused_read_inputs;

    assign unused_read_inputs = ^{rd_op, ad_in};
    assign op_rd   = 1'b0;
    assign rd_n    = 1'b1;
    assign rd_data = '0;
`endif

endmodule
